// File: rtl/sysbus_rr_arbiter.sv
// Round-robin arbiter granting one requester the Sysbus for a whole transaction (request beats + read burst).
// Latency: 1 cycle arbitration in S_IDLE, then request/response paths are combinational through the owner.
// Backpressure: bus_reqack and m_respack[owner] pass straight through; non-owners see no ack until re-granted.
module sysbus_rr_arbiter #(
    parameter int NUM_PORTS      = 2,
    parameter int BUS_DATA_WIDTH = 64,
    parameter int BUS_TAG_WIDTH  = 13,
    parameter int WR_TAG_BIT     = 12,
    parameter int WR_BEATS       = 8,
    parameter int RESP_BEATS     = 8
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic [NUM_PORTS*BUS_DATA_WIDTH-1:0] m_req,
    input  logic [NUM_PORTS-1:0]                m_reqcyc,
    input  logic [NUM_PORTS*BUS_TAG_WIDTH-1:0]  m_reqtag,
    output logic [NUM_PORTS-1:0]                m_reqack,
    output logic [NUM_PORTS-1:0]                m_respcyc,
    output logic [NUM_PORTS*BUS_DATA_WIDTH-1:0] m_resp,
    output logic [NUM_PORTS*BUS_TAG_WIDTH-1:0]  m_resptag,
    input  logic [NUM_PORTS-1:0]                m_respack,
    output logic [BUS_DATA_WIDTH-1:0]           bus_req,
    output logic                                bus_reqcyc,
    output logic [BUS_TAG_WIDTH-1:0]            bus_reqtag,
    input  logic                                bus_reqack,
    input  logic                                bus_respcyc,
    input  logic [BUS_DATA_WIDTH-1:0]           bus_resp,
    input  logic [BUS_TAG_WIDTH-1:0]            bus_resptag,
    output logic                                bus_respack,
    output logic [NUM_PORTS-1:0]                grant,
    output logic                                stray_resp
);

    localparam int IDX_W     = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
    localparam int IW1       = IDX_W + 1;
    localparam int MAX_BEATS = (WR_BEATS > RESP_BEATS) ? WR_BEATS : RESP_BEATS;
    localparam int CNT_W     = $clog2(MAX_BEATS + 1);

    localparam logic [CNT_W-1:0] WR_LAST   = CNT_W'(WR_BEATS - 1);
    localparam logic [CNT_W-1:0] RESP_LAST = CNT_W'(RESP_BEATS - 1);
    localparam logic [IDX_W-1:0] LAST_PORT = IDX_W'(NUM_PORTS - 1);
    localparam logic [IDX_W:0]   NP        = IW1'(NUM_PORTS);

    typedef enum logic [1:0] {S_IDLE, S_ADDR, S_WDATA, S_RESP} state_t;

    state_t               state, state_nxt;
    logic [IDX_W-1:0]     owner, owner_nxt, rr_ptr, rr_ptr_nxt, pick_idx, owner_inc;
    logic [IDX_W:0]       idx_sum;
    logic                 pick_vld;
    logic [NUM_PORTS-1:0] grant_nxt;
    logic [CNT_W-1:0]     beat_cnt, beat_cnt_nxt, resp_cnt, resp_cnt_nxt;

    logic [BUS_DATA_WIDTH-1:0] req_arr [NUM_PORTS];
    logic [BUS_TAG_WIDTH-1:0]  tag_arr [NUM_PORTS];
    logic [NUM_PORTS-1:0]      is_owner;

    logic fwd_req, in_resp, owner_reqcyc, owner_wr, req_beat, resp_beat;

    // state register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= S_IDLE;
            owner      <= '0;
            rr_ptr     <= '0;
            grant      <= '0;
            beat_cnt   <= '0;
            resp_cnt   <= '0;
            stray_resp <= 1'b0;
        end else begin
            state      <= state_nxt;
            owner      <= owner_nxt;
            rr_ptr     <= rr_ptr_nxt;
            grant      <= grant_nxt;
            beat_cnt   <= beat_cnt_nxt;
            resp_cnt   <= resp_cnt_nxt;
            stray_resp <= bus_respcyc && (state != S_RESP);
        end
    end

    // first requester found scanning rr_ptr, rr_ptr+1, ... mod NUM_PORTS
    always_comb begin
        pick_vld = 1'b0;
        pick_idx = '0;
        idx_sum  = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            idx_sum = {1'b0, rr_ptr} + IW1'(i);
            if (idx_sum >= NP)
                idx_sum = idx_sum - NP;
            if (!pick_vld && m_reqcyc[idx_sum[IDX_W-1:0]]) begin
                pick_vld = 1'b1;
                pick_idx = idx_sum[IDX_W-1:0];
            end
        end
    end

    assign owner_inc    = (owner == LAST_PORT) ? '0 : owner + IDX_W'(1);
    assign owner_reqcyc = m_reqcyc[owner];
    assign owner_wr     = tag_arr[owner][WR_TAG_BIT];
    assign req_beat     = bus_reqcyc && bus_reqack;
    assign resp_beat    = in_resp && bus_respcyc && bus_respack;

    // next-state
    always_comb begin
        state_nxt    = state;
        owner_nxt    = owner;
        rr_ptr_nxt   = rr_ptr;
        grant_nxt    = grant;
        beat_cnt_nxt = beat_cnt;
        resp_cnt_nxt = resp_cnt;
        case (state)
            S_IDLE: begin
                if (pick_vld) begin
                    state_nxt = S_ADDR;
                    owner_nxt = pick_idx;
                    grant_nxt = NUM_PORTS'(1) << pick_idx;
                end
            end
            S_ADDR: begin
                if (req_beat) begin
                    if (owner_wr) begin
                        state_nxt    = S_WDATA;
                        beat_cnt_nxt = '0;
                    end else begin
                        state_nxt    = S_RESP;
                        resp_cnt_nxt = '0;
                    end
                end else if (!owner_reqcyc) begin
                    state_nxt  = S_IDLE;
                    grant_nxt  = '0;
                    rr_ptr_nxt = owner_inc;
                end
            end
            S_WDATA: begin
                if (req_beat) begin
                    if (beat_cnt == WR_LAST) begin
                        state_nxt    = S_IDLE;
                        grant_nxt    = '0;
                        rr_ptr_nxt   = owner_inc;
                        beat_cnt_nxt = '0;
                    end else begin
                        beat_cnt_nxt = beat_cnt + CNT_W'(1);
                    end
                end
            end
            S_RESP: begin
                if (resp_beat) begin
                    if (resp_cnt == RESP_LAST) begin
                        state_nxt    = S_IDLE;
                        grant_nxt    = '0;
                        rr_ptr_nxt   = owner_inc;
                        resp_cnt_nxt = '0;
                    end else begin
                        resp_cnt_nxt = resp_cnt + CNT_W'(1);
                    end
                end
            end
            default: begin
                state_nxt = S_IDLE;
                grant_nxt = '0;
            end
        endcase
    end

    // outputs: everything is gated by state so idle and reset drive zeros
    assign fwd_req     = (state == S_ADDR) || (state == S_WDATA);
    assign in_resp     = (state == S_RESP);
    assign bus_req     = fwd_req ? req_arr[owner] : '0;
    assign bus_reqtag  = fwd_req ? tag_arr[owner] : '0;
    assign bus_reqcyc  = fwd_req && owner_reqcyc;
    assign bus_respack = in_resp && m_respack[owner];

    for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
        assign req_arr[p]  = m_req[p*BUS_DATA_WIDTH +: BUS_DATA_WIDTH];
        assign tag_arr[p]  = m_reqtag[p*BUS_TAG_WIDTH +: BUS_TAG_WIDTH];
        assign is_owner[p] = (owner == IDX_W'(p));
        assign m_reqack[p]  = fwd_req && is_owner[p] && bus_reqack;
        assign m_respcyc[p] = in_resp && is_owner[p] && bus_respcyc;
        assign m_resp[p*BUS_DATA_WIDTH +: BUS_DATA_WIDTH] =
            (in_resp && is_owner[p]) ? bus_resp : '0;
        assign m_resptag[p*BUS_TAG_WIDTH +: BUS_TAG_WIDTH] =
            (in_resp && is_owner[p]) ? bus_resptag : '0;
    end

endmodule

// File: tb/tb_sysbus_rr_arbiter.sv
// Bench for sysbus_rr_arbiter (3 ports): directed scenarios, then random traffic against a
// transaction-level round-robin model.
module tb_sysbus_rr_arbiter;
    localparam int N   = 3;
    localparam int DW  = 64;
    localparam int TW  = 13;
    localparam int WRB = 12;
    localparam int WB  = 8;
    localparam int RB  = 8;

    logic            clk = 1'b0;
    logic            reset;
    logic [N*DW-1:0] m_req;
    logic [N-1:0]    m_reqcyc;
    logic [N*TW-1:0] m_reqtag;
    logic [N-1:0]    m_reqack;
    logic [N-1:0]    m_respcyc;
    logic [N*DW-1:0] m_resp;
    logic [N*TW-1:0] m_resptag;
    logic [N-1:0]    m_respack;
    logic [DW-1:0]   bus_req;
    logic            bus_reqcyc;
    logic [TW-1:0]   bus_reqtag;
    logic            bus_reqack;
    logic            bus_respcyc;
    logic [DW-1:0]   bus_resp;
    logic [TW-1:0]   bus_resptag;
    logic            bus_respack;
    logic [N-1:0]    grant;
    logic            stray_resp;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    sysbus_rr_arbiter #(
        .NUM_PORTS(N), .BUS_DATA_WIDTH(DW), .BUS_TAG_WIDTH(TW),
        .WR_TAG_BIT(WRB), .WR_BEATS(WB), .RESP_BEATS(RB)
    ) dut (
        .clk(clk), .reset(reset),
        .m_req(m_req), .m_reqcyc(m_reqcyc), .m_reqtag(m_reqtag), .m_reqack(m_reqack),
        .m_respcyc(m_respcyc), .m_resp(m_resp), .m_resptag(m_resptag), .m_respack(m_respack),
        .bus_req(bus_req), .bus_reqcyc(bus_reqcyc), .bus_reqtag(bus_reqtag), .bus_reqack(bus_reqack),
        .bus_respcyc(bus_respcyc), .bus_resp(bus_resp), .bus_resptag(bus_resptag),
        .bus_respack(bus_respack), .grant(grant), .stray_resp(stray_resp)
    );

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        m_req = '0; m_reqcyc = '0; m_reqtag = '0; m_respack = '0;
        bus_reqack = 1'b0; bus_respcyc = 1'b0; bus_resp = '0; bus_resptag = '0;
    endtask

    task automatic do_reset();
        clear_inputs();
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #2 reset = 1'b1;
    endtask

    function automatic logic [TW-1:0] mk_tag(input int p, input bit wr);
        logic [TW-1:0] t;
        t = TW'(p + 5);
        t[WRB] = wr;
        return t;
    endfunction

    task automatic drive_port(input int p, input bit v, input bit wr, input logic [DW-1:0] d);
        m_reqcyc[p] = v;
        m_reqtag[p*TW +: TW] = mk_tag(p, wr);
        m_req[p*DW +: DW] = d;
    endtask

    // first requesting port scanning ptr, ptr+1, ... mod N; -1 if none
    function automatic int rr_pick(input int ptr, input logic [N-1:0] req);
        for (int i = 0; i < N; i++)
            if (req[(ptr + i) % N]) return (ptr + i) % N;
        return -1;
    endfunction

    function automatic int onehot_idx(input logic [N-1:0] g);
        for (int i = 0; i < N; i++)
            if (g[i]) return i;
        return -1;
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog simulation did not finish (tests=%0d fails=%0d)", tests, fails);
        $fatal(1, "timeout");
    end

    initial begin
        int order[$];
        int beats_q[$];
        logic [N-1:0] pg;
        int bc, beats, k, rb;
        bit ackph, leak, dbad, tbad;
        // random-phase model state
        int mptr, own, pk, treq, tresp, tcyc;
        logic [N-1:0] preq, pgr, exp_oh;
        logic [N*DW-1:0] exp_resp;
        logic [N*TW-1:0] exp_rtag;
        bit pbr, pinr, cwr, inreq, inrsp;
        bit want[N];
        bit iswr[N];
        int sent[N];

        // ---- reset state ----
        clear_inputs();
        reset = 1'b1;
        #1 reset = 1'b0;
        #1;
        chk("rst_grant", grant, 0);
        chk("rst_bus_reqcyc", bus_reqcyc, 0);
        chk("rst_bus_req", bus_req, 0);
        chk("rst_m_reqack", m_reqack, 0);
        chk("rst_m_respcyc", m_respcyc, 0);
        chk("rst_bus_respack", bus_respack, 0);
        chk("rst_stray", stray_resp, 0);

        // ---- reset in the middle of a read response ----
        do_reset();
        drive_port(1, 1, 0, 64'h11);
        cyc();
        chk("mr_grant", grant, 3'b010);
        bus_reqack = 1'b1;
        #1 chk("mr_reqack", m_reqack, 3'b010);
        cyc();
        drive_port(1, 0, 0, 0);
        bus_reqack = 1'b0; bus_respcyc = 1'b1; bus_resp = 64'h1234; m_respack = 3'b010;
        #1;
        chk("mr_respcyc", m_respcyc, 3'b010);
        chk("mr_resp", m_resp[DW +: DW], 64'h1234);
        reset = 1'b0;
        #1;
        chk("mr_rst_grant", grant, 0);
        chk("mr_rst_respcyc", m_respcyc, 0);
        chk("mr_rst_resp", m_resp, 0);
        chk("mr_rst_respack", bus_respack, 0);
        clear_inputs();
        m_reqcyc = 3'b111;
        #1 reset = 1'b1;
        cyc();
        chk("mr_first_grant", grant, 3'b001);

        // ---- fairness: three back-to-back readers ----
        do_reset();
        for (int p = 0; p < N; p++) drive_port(p, 1, 0, 64'(p));
        bus_reqack = 1'b1; bus_respcyc = 1'b1; m_respack = 3'b111; bus_resp = 64'hCAFE;
        pg = '0; bc = 0;
        for (int c = 0; c < 64; c++) begin
            cyc();
            if (pg == 0 && grant != 0) begin
                order.push_back(onehot_idx(grant));
                bc = 0;
            end
            if (grant != 0 && (m_respcyc & m_respack & grant) != 0) bc++;
            if (pg != 0 && grant == 0) beats_q.push_back(bc);
            pg = grant;
        end
        chk("fair_tenures", order.size() >= 6 && beats_q.size() >= 6, 1);
        for (int i = 0; i < 6; i++) begin
            if (i < order.size())   chk("fair_order", order[i], i % N);
            if (i < beats_q.size()) chk("fair_resp_beats", beats_q[i], RB);
        end

        // ---- write from port 1 with half-rate reqack; port 0 waits ----
        do_reset();
        drive_port(1, 1, 1, 0);
        cyc();
        chk("wr_grant", grant, 3'b010);
        drive_port(0, 1, 0, 64'hA0);
        beats = 0; ackph = 0; leak = 0; dbad = 0; tbad = 0; k = 0;
        while (grant == 3'b010 && k < 60) begin
            bus_reqack = ackph;
            ackph = !ackph;
            drive_port(1, beats < WB + 1, 1, 64'(beats));
            #1;
            if (m_reqack[0]) leak = 1;
            if (bus_reqcyc && bus_reqack) begin
                if (bus_req != 64'(beats)) dbad = 1;
                if (bus_reqtag != mk_tag(1, 1)) tbad = 1;
                beats++;
            end
            cyc();
            k++;
        end
        chk("wr_beats", beats, WB + 1);
        chk("wr_p0_unacked", leak, 0);
        chk("wr_data", dbad, 0);
        chk("wr_tag", tbad, 0);
        chk("wr_idle_gap", grant, 0);
        drive_port(1, 0, 0, 0);
        bus_reqack = 1'b0;
        cyc();
        chk("wr_next_p0", grant, 3'b001);

        // ---- response routing with m_respack stalls ----
        do_reset();
        drive_port(0, 1, 0, 64'hB0);
        drive_port(1, 1, 0, 64'hB1);
        cyc();
        chk("rt_grant", grant, 3'b001);
        bus_reqack = 1'b1;
        cyc();
        drive_port(0, 0, 0, 0);
        bus_reqack = 1'b0; bus_respcyc = 1'b1; bus_resp = 64'hDEAD_BEEF;
        rb = 0; k = 0;
        while (grant == 3'b001 && k < 40) begin
            m_respack = {2'b11, (k % 3) != 1};
            #1;
            chk("rt_respack", bus_respack, m_respack[0]);
            chk("rt_respcyc", m_respcyc, 3'b001);
            chk("rt_resp0", m_resp[0 +: DW], 64'hDEAD_BEEF);
            chk("rt_resp1", m_resp[DW +: DW], 0);
            if (bus_respack) rb++;
            cyc();
            k++;
        end
        chk("rt_beats", rb, RB);
        bus_respcyc = 1'b0;
        cyc();
        chk("rt_next_p1", grant, 3'b010);

        // ---- stray response while idle ----
        do_reset();
        bus_respcyc = 1'b1;
        #1;
        chk("st_respack", bus_respack, 0);
        chk("st_respcyc", m_respcyc, 0);
        chk("st_before", stray_resp, 0);
        cyc();
        bus_respcyc = 1'b0;
        chk("st_pulse", stray_resp, 1);
        cyc();
        chk("st_clear", stray_resp, 0);

        // ---- abort: owner drops reqcyc before reqack ----
        do_reset();
        drive_port(1, 1, 0, 64'h1);
        cyc();
        chk("ab_grant", grant, 3'b010);
        drive_port(1, 0, 0, 0);
        #1 chk("ab_no_beat", bus_reqcyc, 0);
        cyc();
        chk("ab_idle", grant, 0);
        for (int p = 0; p < N; p++) drive_port(p, 1, 0, 0);
        cyc();
        chk("ab_rr_next", grant, 3'b100);
        drive_port(2, 0, 0, 0);
        cyc();
        chk("ab_idle2", grant, 0);
        cyc();
        chk("ab_wrap", grant, 3'b001);

        // ---- random traffic vs transaction-level model ----
        do_reset();
        mptr = 0; preq = '0; pgr = '0; pbr = 0; pinr = 0;
        own = 0; cwr = 0; treq = 0; tresp = 0; tcyc = 0;
        for (int p = 0; p < N; p++) begin want[p] = 0; iswr[p] = 0; sent[p] = 0; end
        for (int c = 0; c < 1500; c++) begin
            cyc();
            if (pgr == 0) begin
                pk = rr_pick(mptr, preq);
                chk("rnd_grant", grant, (pk < 0) ? 0 : (1 << pk));
                if (pk >= 0) begin
                    own = pk; cwr = iswr[pk]; treq = 0; tresp = 0; tcyc = 0;
                end
            end else if (grant == 0) begin
                chk("rnd_req_beats", treq, cwr ? WB + 1 : 1);
                chk("rnd_resp_beats", tresp, cwr ? 0 : RB);
                mptr = (own + 1) % N;
            end else begin
                chk("rnd_hold", grant, pgr);
                tcyc++;
                chk("rnd_tenure_bound", tcyc < 200, 1);
            end
            chk("rnd_stray", stray_resp, pbr && !pinr);

            for (int p = 0; p < N; p++) begin
                if (!want[p] && $urandom_range(3) == 0) begin
                    want[p] = 1; iswr[p] = 1'($urandom_range(1)); sent[p] = 0;
                end
                drive_port(p, want[p], iswr[p], {$urandom, $urandom});
            end
            bus_reqack  = 1'($urandom_range(1));
            bus_respcyc = 1'($urandom_range(1));
            bus_resp    = {$urandom, $urandom};
            bus_resptag = TW'($urandom);
            m_respack   = N'($urandom);
            #1;

            inreq  = (grant != 0) && (treq < (cwr ? WB + 1 : 1));
            inrsp  = (grant != 0) && !inreq;
            exp_oh = N'(1) << own;
            exp_resp = '0;
            exp_rtag = '0;
            if (inrsp) begin
                exp_resp[own*DW +: DW] = bus_resp;
                exp_rtag[own*TW +: TW] = bus_resptag;
            end
            chk("rnd_bus_reqcyc", bus_reqcyc, inreq && m_reqcyc[own]);
            chk("rnd_bus_req", bus_req, inreq ? m_req[own*DW +: DW] : 0);
            chk("rnd_bus_reqtag", bus_reqtag, inreq ? m_reqtag[own*TW +: TW] : 0);
            chk("rnd_m_reqack", m_reqack, (inreq && bus_reqack) ? exp_oh : 0);
            chk("rnd_m_respcyc", m_respcyc, (inrsp && bus_respcyc) ? exp_oh : 0);
            chk("rnd_m_resp", m_resp, exp_resp);
            chk("rnd_m_resptag", m_resptag, exp_rtag);
            chk("rnd_bus_respack", bus_respack, inrsp && m_respack[own]);

            if (inreq && m_reqcyc[own] && bus_reqack) treq++;
            if (inrsp && bus_respcyc && m_respack[own]) tresp++;
            for (int p = 0; p < N; p++) begin
                if (m_reqcyc[p] && m_reqack[p]) begin
                    sent[p]++;
                    if (sent[p] >= (iswr[p] ? WB + 1 : 1)) want[p] = 0;
                end
            end
            preq = m_reqcyc; pgr = grant; pbr = bus_respcyc; pinr = inrsp;
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
